// File: rtl/lisnoc_router_output_vc.sv
// LISNoC router output stage: per-VC wormhole arbitration across input ports,
// then round-robin VC multiplexing into one registered, VC-tagged output flit.
module lisnoc_router_output_vc #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ports           = 5,
  parameter int vchannels       = 1
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic [ports*vchannels*(flit_data_width+flit_type_width)-1:0] in_flit_i,
  input  logic [ports*vchannels-1:0]                                   in_valid_i,
  output logic [ports*vchannels-1:0]                                   in_ready_o,
  output logic [flit_data_width+flit_type_width-1:0]                   out_flit_o,
  output logic [vchannels-1:0]                                         out_valid_o,
  input  logic [vchannels-1:0]                                         out_ready_i
);

  localparam int flit_width = flit_data_width + flit_type_width;
  localparam int PW = (ports > 1) ? $clog2(ports) : 1;
  localparam int VW = (vchannels > 1) ? $clog2(vchannels) : 1;

  localparam logic [flit_type_width-1:0] TYPE_HEADER = flit_type_width'(2'b01);
  localparam logic [flit_type_width-1:0] TYPE_LAST   = flit_type_width'(2'b10);
  localparam logic [flit_type_width-1:0] TYPE_SINGLE = flit_type_width'(2'b11);

  typedef enum logic {S_IDLE, S_LOCKED} vc_state_e;

  vc_state_e             r_state     [vchannels];
  logic [PW-1:0]         r_owner     [vchannels];
  logic [PW-1:0]         r_pptr      [vchannels];
  logic [VW-1:0]         r_vc_ptr;

  vc_state_e             w_state_nxt [vchannels];
  logic [PW-1:0]         w_owner_nxt [vchannels];
  logic [PW-1:0]         w_pptr_nxt  [vchannels];
  logic [VW-1:0]         w_vc_ptr_nxt;

  logic [flit_width-1:0] w_in_flit   [ports*vchannels];
  logic [ports-1:0]      w_req       [vchannels];
  logic [PW-1:0]         w_cand_port [vchannels];
  logic [vchannels-1:0]  w_has_cand;
  logic                  w_any;
  logic [VW-1:0]         w_win_vc;
  logic [PW-1:0]         w_win_port;
  logic [flit_width-1:0] w_win_flit;
  logic [vchannels-1:0]  w_win_onehot;
  logic                  w_drain;
  logic                  w_load;

  function automatic logic [flit_type_width-1:0] type_of(input logic [flit_width-1:0] f);
    return f[flit_width-1 -: flit_type_width];
  endfunction

  function automatic logic [PW-1:0] inc_port(input logic [PW-1:0] x);
    return (x == PW'(ports - 1)) ? '0 : x + 1'b1;
  endfunction

  function automatic logic [VW-1:0] inc_vc(input logic [VW-1:0] x);
    return (x == VW'(vchannels - 1)) ? '0 : x + 1'b1;
  endfunction

  // Round-robin pick: first request at or above ptr, else wrap to the lowest one.
  function automatic logic [PW:0] pick_port(input logic [ports-1:0] req, input logic [PW-1:0] ptr);
    logic          hi_found, lo_found;
    logic [PW-1:0] hi, lo;
    hi_found = 1'b0; lo_found = 1'b0; hi = '0; lo = '0;
    for (int p = 0; p < ports; p++) begin
      if (req[p]) begin
        if (!hi_found && PW'(p) >= ptr) begin hi_found = 1'b1; hi = PW'(p); end
        if (!lo_found) begin lo_found = 1'b1; lo = PW'(p); end
      end
    end
    return {lo_found, hi_found ? hi : lo};
  endfunction

  function automatic logic [VW:0] pick_vc(input logic [vchannels-1:0] req, input logic [VW-1:0] ptr);
    logic          hi_found, lo_found;
    logic [VW-1:0] hi, lo;
    hi_found = 1'b0; lo_found = 1'b0; hi = '0; lo = '0;
    for (int v = 0; v < vchannels; v++) begin
      if (req[v]) begin
        if (!hi_found && VW'(v) >= ptr) begin hi_found = 1'b1; hi = VW'(v); end
        if (!lo_found) begin lo_found = 1'b1; lo = VW'(v); end
      end
    end
    return {lo_found, hi_found ? hi : lo};
  endfunction

  always_comb begin
    for (int k = 0; k < ports*vchannels; k++) begin
      w_in_flit[k] = in_flit_i[k*flit_width +: flit_width];
    end
  end

  // A locked VC listens only to its owner; an idle VC only to head flits.
  always_comb begin
    for (int v = 0; v < vchannels; v++) begin
      for (int p = 0; p < ports; p++) begin
        if (r_state[v] == S_LOCKED) begin
          w_req[v][p] = in_valid_i[p*vchannels+v] && (r_owner[v] == PW'(p));
        end else begin
          w_req[v][p] = in_valid_i[p*vchannels+v] &&
                        (type_of(w_in_flit[p*vchannels+v]) == TYPE_HEADER ||
                         type_of(w_in_flit[p*vchannels+v]) == TYPE_SINGLE);
        end
      end
      {w_has_cand[v], w_cand_port[v]} = pick_port(w_req[v], r_pptr[v]);
    end
  end

  assign {w_any, w_win_vc} = pick_vc(w_has_cand, r_vc_ptr);
  assign w_drain = |(out_valid_o & out_ready_i);
  assign w_load  = w_any && (!(|out_valid_o) || w_drain) && !rst;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_ready_o   = '0;
    w_win_flit   = '0;
    w_win_port   = '0;
    w_win_onehot = '0;
    for (int v = 0; v < vchannels; v++) begin
      if (w_win_vc == VW'(v)) begin
        w_win_onehot[v] = 1'b1;
        w_win_port      = w_cand_port[v];
        for (int p = 0; p < ports; p++) begin
          if (w_cand_port[v] == PW'(p)) begin
            w_win_flit                = w_in_flit[p*vchannels+v];
            in_ready_o[p*vchannels+v] = w_load;
          end
        end
      end
    end
  end

  always_comb begin
    w_vc_ptr_nxt = r_vc_ptr;
    for (int v = 0; v < vchannels; v++) begin
      w_state_nxt[v] = r_state[v];
      w_owner_nxt[v] = r_owner[v];
      w_pptr_nxt[v]  = r_pptr[v];
      if (w_load && w_win_vc == VW'(v)) begin
        case (r_state[v])
          S_IDLE: begin
            if (type_of(w_win_flit) == TYPE_HEADER) begin
              w_state_nxt[v] = S_LOCKED;
              w_owner_nxt[v] = w_win_port;
            end else begin
              w_pptr_nxt[v] = inc_port(w_win_port);
            end
          end
          S_LOCKED: begin
            if (type_of(w_win_flit) == TYPE_LAST) begin
              w_state_nxt[v] = S_IDLE;
              w_pptr_nxt[v]  = inc_port(r_owner[v]);
            end
          end
          default: w_state_nxt[v] = S_IDLE;
        endcase
      end
    end
    if (w_load) w_vc_ptr_nxt = inc_vc(w_win_vc);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flit_o  <= '0;
      out_valid_o <= '0;
      r_vc_ptr    <= '0;
      for (int v = 0; v < vchannels; v++) begin
        r_state[v] <= S_IDLE;
        r_owner[v] <= '0;
        r_pptr[v]  <= '0;
      end
    end else begin
      r_vc_ptr <= w_vc_ptr_nxt;
      for (int v = 0; v < vchannels; v++) begin
        r_state[v] <= w_state_nxt[v];
        r_owner[v] <= w_owner_nxt[v];
        r_pptr[v]  <= w_pptr_nxt[v];
      end
      if (w_load) begin
        out_flit_o  <= w_win_flit;
        out_valid_o <= w_win_onehot;
      end else if (w_drain) begin
        out_valid_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lisnoc_router_output_vc.sv
// Directed bench for lisnoc_router_output_vc (5 ports, 2 VCs, 32-bit payload).
module tb_lisnoc_router_output_vc;

  localparam int P  = 5;
  localparam int V  = 2;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int FW = DW + TW;
  localparam int NR = P * V;

  localparam logic [1:0] T_PAY = 2'b00;
  localparam logic [1:0] T_HDR = 2'b01;
  localparam logic [1:0] T_LST = 2'b10;
  localparam logic [1:0] T_SGL = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*FW-1:0] in_flit;
  logic [NR-1:0]   in_valid;
  logic [NR-1:0]   in_ready;
  logic [FW-1:0]   out_flit;
  logic [V-1:0]    out_valid;
  logic [V-1:0]    out_ready;

  int n_cmp = 0;
  int n_mis = 0;

  lisnoc_router_output_vc #(
    .flit_data_width (DW),
    .flit_type_width (TW),
    .ports           (P),
    .vchannels       (V)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_flit_i   (in_flit),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .out_flit_o  (out_flit),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int p, input int v, input logic [1:0] t, input logic [31:0] d);
    in_flit[(p*V+v)*FW +: FW] = {t, d};
    in_valid[p*V+v]           = 1'b1;
  endtask

  task automatic idle(input int p, input int v);
    in_valid[p*V+v] = 1'b0;
  endtask

  function automatic logic [NR-1:0] rdy(input int p, input int v);
    return NR'(1) << (p*V + v);
  endfunction

  task automatic do_reset();
    in_valid  = '0;
    out_ready = '1;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst       = 1'b1;
    out_ready = '1;
    in_flit   = '0;
    in_valid  = '0;
    for (int p = 0; p < P; p++)
      for (int v = 0; v < V; v++) begin
        d = 32'h100 + 32'(p*16 + v);
        drive(p, v, T_SGL, d);
      end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (in_ready !== '0) begin
        n_mis++; $display("FAIL reset_ready c%0d: got %b want 0", c, in_ready);
      end
      n_cmp++;
      if ({out_valid, out_flit} !== '0) begin
        n_mis++; $display("FAIL reset_out c%0d: got %b/%h want 0/0", c, out_valid, out_flit);
      end
      n_cmp++;
    end
    rst = 1'b0;
    settle();
    if (in_ready !== rdy(0, 0) || out_valid !== 2'b00) begin
      n_mis++; $display("FAIL reset_first_grant: got %b/%b want %b/00", in_ready, out_valid, rdy(0, 0));
    end
    n_cmp++;
    tick();
    if ({out_valid, out_flit} !== {2'b01, T_SGL, 32'h100}) begin
      n_mis++; $display("FAIL reset_first_out: got %b/%h want 01/%h", out_valid, out_flit, {T_SGL, 32'h100});
    end
    n_cmp++;
    in_valid = '0;
  endtask

  task automatic test_wormhole();
    logic [1:0]  ty  [3];
    logic [31:0] dat [3];
    ty  = '{T_HDR, T_PAY, T_LST};
    dat = '{32'h11, 32'h12, 32'h13};
    do_reset();
    drive(3, 0, T_HDR, 32'h31);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, ty[i], dat[i]);
      settle();
      if (in_ready !== rdy(1, 0)) begin
        n_mis++; $display("FAIL wormhole_ready%0d: got %b want %b", i, in_ready, rdy(1, 0));
      end
      n_cmp++;
      tick();
      if ({out_valid, out_flit} !== {2'b01, ty[i], dat[i]}) begin
        n_mis++; $display("FAIL wormhole_out%0d: got %b/%h want 01/%h", i, out_valid, out_flit, {ty[i], dat[i]});
      end
      n_cmp++;
    end
    idle(1, 0);
    settle();
    if (in_ready !== rdy(3, 0)) begin
      n_mis++; $display("FAIL wormhole_next_ready: got %b want %b", in_ready, rdy(3, 0));
    end
    n_cmp++;
    tick();
    if ({out_valid, out_flit} !== {2'b01, T_HDR, 32'h31}) begin
      n_mis++; $display("FAIL wormhole_next_out: got %b/%h want 01/%h", out_valid, out_flit, {T_HDR, 32'h31});
    end
    n_cmp++;
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    int          order [6];
    logic [31:0] d;
    order = '{0, 2, 4, 0, 2, 4};
    do_reset();
    drive(0, 0, T_SGL, 32'hA0);
    drive(2, 0, T_SGL, 32'hA2);
    drive(4, 0, T_SGL, 32'hA4);
    for (int i = 0; i < 6; i++) begin
      d = 32'hA0 + 32'(order[i]);
      settle();
      if (in_ready !== rdy(order[i], 0)) begin
        n_mis++; $display("FAIL rr_grant%0d: got %b want %b", i, in_ready, rdy(order[i], 0));
      end
      n_cmp++;
      tick();
      if ({out_valid, out_flit} !== {2'b01, T_SGL, d}) begin
        n_mis++; $display("FAIL rr_out%0d: got %b/%h want 01/%h", i, out_valid, out_flit, {T_SGL, d});
      end
      n_cmp++;
    end
    in_valid = '0;
  endtask

  task automatic test_vc_interleave();
    logic [1:0]    ty [3];
    int            idx0, idx1, ei;
    logic          got0, got1;
    logic [V-1:0]  exp_v;
    logic [31:0]   exp_d;
    logic [NR-1:0] exp_r;
    ty   = '{T_HDR, T_PAY, T_LST};
    idx0 = 0;
    idx1 = 0;
    do_reset();
    drive(0, 0, ty[0], 32'h01);
    drive(1, 1, ty[0], 32'h11);
    for (int c = 0; c < 6; c++) begin
      ei    = c / 2;
      exp_v = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (c % 2 == 0) ? rdy(0, 0) : rdy(1, 1);
      exp_d = ((c % 2 == 0) ? 32'h01 : 32'h11) + 32'(ei);
      settle();
      if (in_ready !== exp_r) begin
        n_mis++; $display("FAIL vc_ready%0d: got %b want %b", c, in_ready, exp_r);
      end
      n_cmp++;
      got0 = in_ready[0*V+0];
      got1 = in_ready[1*V+1];
      tick();
      if ({out_valid, out_flit} !== {exp_v, ty[ei], exp_d}) begin
        n_mis++; $display("FAIL vc_out%0d: got %b/%h want %b/%h", c, out_valid, out_flit, exp_v, {ty[ei], exp_d});
      end
      n_cmp++;
      if (got0) begin
        idx0++;
        if (idx0 < 3) drive(0, 0, ty[idx0], 32'h01 + 32'(idx0)); else idle(0, 0);
      end
      if (got1) begin
        idx1++;
        if (idx1 < 3) drive(1, 1, ty[idx1], 32'h11 + 32'(idx1)); else idle(1, 1);
      end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 2'b10;
    drive(0, 0, T_SGL, 32'hAA);
    settle();
    if (in_ready !== rdy(0, 0)) begin
      n_mis++; $display("FAIL bp_load_ready: got %b want %b", in_ready, rdy(0, 0));
    end
    n_cmp++;
    tick();
    drive(0, 0, T_SGL, 32'hBB);
    drive(1, 1, T_SGL, 32'hCC);
    for (int c = 0; c < 4; c++) begin
      settle();
      if (in_ready !== '0) begin
        n_mis++; $display("FAIL bp_stall_ready%0d: got %b want 0", c, in_ready);
      end
      n_cmp++;
      if ({out_valid, out_flit} !== {2'b01, T_SGL, 32'hAA}) begin
        n_mis++; $display("FAIL bp_stall_out%0d: got %b/%h want 01/%h", c, out_valid, out_flit, {T_SGL, 32'hAA});
      end
      n_cmp++;
      tick();
    end
    out_ready = 2'b11;
    settle();
    if (in_ready !== rdy(1, 1)) begin
      n_mis++; $display("FAIL bp_release_ready: got %b want %b", in_ready, rdy(1, 1));
    end
    n_cmp++;
    tick();
    if ({out_valid, out_flit} !== {2'b10, T_SGL, 32'hCC}) begin
      n_mis++; $display("FAIL bp_release_out: got %b/%h want 10/%h", out_valid, out_flit, {T_SGL, 32'hCC});
    end
    n_cmp++;
    idle(1, 1);
    settle();
    if (in_ready !== rdy(0, 0)) begin
      n_mis++; $display("FAIL bp_next_ready: got %b want %b", in_ready, rdy(0, 0));
    end
    n_cmp++;
    tick();
    if ({out_valid, out_flit} !== {2'b01, T_SGL, 32'hBB}) begin
      n_mis++; $display("FAIL bp_next_out: got %b/%h want 01/%h", out_valid, out_flit, {T_SGL, 32'hBB});
    end
    n_cmp++;
    idle(0, 0);
    tick();
    if (out_valid !== 2'b00) begin
      n_mis++; $display("FAIL bp_empty: got %b want 00", out_valid);
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(2, 0, T_HDR, 32'h21);
    settle();
    if (in_ready !== rdy(2, 0)) begin
      n_mis++; $display("FAIL midrst_hdr_ready: got %b want %b", in_ready, rdy(2, 0));
    end
    n_cmp++;
    tick();
    drive(2, 0, T_PAY, 32'h22);
    drive(4, 0, T_HDR, 32'h41);
    rst = 1'b1;
    settle();
    if (in_ready !== '0) begin
      n_mis++; $display("FAIL midrst_ready_in_rst: got %b want 0", in_ready);
    end
    n_cmp++;
    tick();
    if ({out_valid, out_flit} !== '0) begin
      n_mis++; $display("FAIL midrst_out_cleared: got %b/%h want 0/0", out_valid, out_flit);
    end
    n_cmp++;
    rst = 1'b0;
    settle();
    if (in_ready !== rdy(4, 0)) begin
      n_mis++; $display("FAIL midrst_new_owner_ready: got %b want %b", in_ready, rdy(4, 0));
    end
    n_cmp++;
    tick();
    if ({out_valid, out_flit} !== {2'b01, T_HDR, 32'h41}) begin
      n_mis++; $display("FAIL midrst_new_owner_out: got %b/%h want 01/%h", out_valid, out_flit, {T_HDR, 32'h41});
    end
    n_cmp++;
    in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_wormhole();
    test_round_robin();
    test_vc_interleave();
    test_backpressure();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
